dynamic_clock_gating: RTL and testbench

Activity-driven clock gate for a downstream logic island. It samples a single `activity` request in the source clock domain and drives a gated copy of that clock. The gated clock toggles only while the island is requested. The gate is glitch-free and latch-based, equivalent to an integrated clock-gating (ICG) cell. It sits between the clock root and the gated domain, with an optional idle hold-off and a saturating gated-cycle counter for power monitoring.

---
 rtl/dynamic_clock_gating.sv | 66 ++++++
 tb/tb_dynamic_clock_gating.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/dynamic_clock_gating.sv
// Activity-driven, latch-based clock gate (ICG equivalent) with optional idle
// hold-off and a saturating counter of suppressed clock cycles.
`timescale 1ns/1ps
module dynamic_clock_gating #(
    parameter int IDLE_HOLD = 0,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 activity,
    output logic                 gated_clk,
    output logic                 clk_en,
    output logic [CNT_WIDTH-1:0] gated_cycles
);

    // A zero hold-off still gets a 1-bit counter; it simply never loads non-zero.
    localparam int                HOLD_W    = (IDLE_HOLD > 0) ? $clog2(IDLE_HOLD + 1) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(IDLE_HOLD);

    logic [HOLD_W-1:0] hold_cnt;
    logic              en_q;
    logic              en_lat;

    // Hysteresis counter: reload while active, drain toward zero while idle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_cnt <= '0;
        end else if (activity) begin
            hold_cnt <= HOLD_LOAD;
        end else if (hold_cnt != '0) begin
            hold_cnt <= hold_cnt - HOLD_W'(1);
        end
    end

    // Registered enable; stays high while requested or while hold-off remains.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            en_q <= 1'b0;
        end else begin
            en_q <= activity | (hold_cnt != '0);
        end
    end

    // Enable latch, transparent in the low phase so it can never move while clk is high.
    always_latch begin
        if (!reset_n) begin
            en_lat <= 1'b0;
        end else if (!clk) begin
            en_lat <= en_q;
        end
    end

    // Gated-cycle statistics: count edges where the island saw no clock, saturating.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            gated_cycles <= '0;
        end else if (!en_lat && (gated_cycles != '1)) begin
            gated_cycles <= gated_cycles + CNT_WIDTH'(1);
        end
    end

    // Only an AND after the latch on the clock path.
    assign gated_clk = clk & en_lat;
    assign clk_en    = en_q;

endmodule

// File: tb/tb_dynamic_clock_gating.sv
// Directed bench for dynamic_clock_gating: three instances (default, hold-off 3,
// 4-bit counter) share clock, reset and activity; a queue per instance holds the
// expected gated pulse for each upcoming clock high phase.
`timescale 1ns/1ps
module tb_dynamic_clock_gating;

    logic        clk;
    logic        reset_n;
    logic        activity;

    logic        gclk_a, en_a;
    logic [15:0] cnt_a;
    logic        gclk_h, en_h;
    logic [15:0] cnt_h;
    logic        gclk_s, en_s;
    logic [3:0]  cnt_s;

    int checks = 0;
    int errors = 0;

    bit          q_a[$];
    bit          q_h[$];
    bit          q_s[$];
    int          m_hold;
    int          m_cnt_a, m_cnt_h, m_cnt_s;

    int          pulses_a = 0;
    int          pulses_h = 0;
    time         rise_a, rise_h;

    dynamic_clock_gating u_a (
        .clk(clk), .reset_n(reset_n), .activity(activity),
        .gated_clk(gclk_a), .clk_en(en_a), .gated_cycles(cnt_a)
    );

    dynamic_clock_gating #(.IDLE_HOLD(3)) u_h (
        .clk(clk), .reset_n(reset_n), .activity(activity),
        .gated_clk(gclk_h), .clk_en(en_h), .gated_cycles(cnt_h)
    );

    dynamic_clock_gating #(.CNT_WIDTH(4)) u_s (
        .clk(clk), .reset_n(reset_n), .activity(activity),
        .gated_clk(gclk_s), .clk_en(en_s), .gated_cycles(cnt_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Pulse width monitors: every gated high pulse must be a full 5 ns clk high phase.
    always @(posedge gclk_a) begin
        rise_a = $time;
        pulses_a++;
    end
    always @(negedge gclk_a) if (reset_n) chk("pulse_width_a", 32'(($time - rise_a) >= 5), 1);
    always @(posedge gclk_h) begin
        rise_h = $time;
        pulses_h++;
    end
    always @(negedge gclk_h) if (reset_n) chk("pulse_width_h", 32'(($time - rise_h) >= 5), 1);

    task automatic model_clear();
        q_a = {1'b0};
        q_h = {1'b0};
        q_s = {1'b0};
        m_hold  = 0;
        m_cnt_a = 0;
        m_cnt_h = 0;
        m_cnt_s = 0;
    endtask

    // One clock: drive activity, push expectations, check the high and low phases.
    task automatic step(input bit act);
        bit pa, ph, ps;
        activity = act;
        q_a.push_back(act);
        q_s.push_back(act);
        q_h.push_back(act | (m_hold != 0));
        m_hold = act ? 3 : ((m_hold > 0) ? m_hold - 1 : 0);

        @(posedge clk);
        #2;
        pa = q_a.pop_front();
        ph = q_h.pop_front();
        ps = q_s.pop_front();
        if (!pa && m_cnt_a != 16'hffff) m_cnt_a++;
        if (!ph && m_cnt_h != 16'hffff) m_cnt_h++;
        if (!ps && m_cnt_s != 15) m_cnt_s++;
        chk("gclk_high_a", 32'(gclk_a), 32'(pa));
        chk("gclk_high_h", 32'(gclk_h), 32'(ph));
        chk("gclk_high_s", 32'(gclk_s), 32'(ps));
        chk("clk_en_a", 32'(en_a), 32'(q_a[0]));
        chk("clk_en_h", 32'(en_h), 32'(q_h[0]));
        chk("cnt_a", 32'(cnt_a), 32'(m_cnt_a));
        chk("cnt_h", 32'(cnt_h), 32'(m_cnt_h));
        chk("cnt_s", 32'(cnt_s), 32'(m_cnt_s));

        @(negedge clk);
        #2;
        chk("gclk_low_a", 32'(gclk_a), 0);
        chk("gclk_low_h", 32'(gclk_h), 0);
    endtask

    // Assert reset in a low phase with the given activity, hold it two cycles, release after a posedge.
    task automatic do_reset(input bit act);
        @(negedge clk);
        #1;
        reset_n  = 1'b0;
        activity = act;
        #1;
        chk("rst_clk_en_a", 32'(en_a), 0);
        chk("rst_clk_en_h", 32'(en_h), 0);
        chk("rst_cnt_a", 32'(cnt_a), 0);
        repeat (2) begin
            @(posedge clk);
            #2;
            chk("rst_gclk_a", 32'(gclk_a), 0);
            chk("rst_gclk_h", 32'(gclk_h), 0);
            chk("rst_clk_en_s", 32'(en_s), 0);
            chk("rst_cnt_s", 32'(cnt_s), 0);
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_clear();
    endtask

    initial begin
        int base_a, base_h;
        reset_n  = 1'b0;
        activity = 1'b0;
        model_clear();

        do_reset(1'b0);

        // Idle after reset: no clock, counter counts every edge.
        repeat (5) step(1'b0);

        // Enable: clock follows from the second edge, counter frozen.
        repeat (5) step(1'b1);

        // Toggle every three cycles.
        for (int i = 0; i < 5; i++) begin
            repeat (3) step(i[0] ? 1'b1 : 1'b0);
        end

        // Reset while requested, then release with activity held high.
        do_reset(1'b1);
        repeat (4) step(1'b1);

        // Single-cycle request: one pulse by default, four with hold-off 3.
        repeat (4) step(1'b0);
        base_a = pulses_a;
        base_h = pulses_h;
        step(1'b1);
        repeat (7) step(1'b0);
        chk("single_pulse_count_a", 32'(pulses_a - base_a), 1);
        chk("single_pulse_count_h", 32'(pulses_h - base_h), 4);

        // Saturation of the 4-bit counter after 20 idle cycles.
        do_reset(1'b0);
        repeat (20) step(1'b0);
        chk("sat_cnt_s", 32'(cnt_s), 15);
        chk("sat_cnt_a", 32'(cnt_a), 20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
